// File: rtl/apb3_mem_pkg.sv
// Shared constants, helpers and the wait-state FSM encoding for the APB3 memory completer.
package apb3_mem_pkg;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1024;

  // Number of paddr bits that select a byte within one data word.
  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } wait_state_e;

endpackage

// File: rtl/apb3_mem_completer_if.sv
// APB3 bus bundle between one requester and the memory completer.
interface apb3_mem_completer_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] paddr;
  logic                    pwrite;
  logic                    psel;
  logic                    penable;
  logic [DataWidth-1:0]    pwdata;
  logic [DataWidth-1:0]    prdata;
  logic                    pready;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb3_mem_array.sv
// Synchronous single-port RAM; registered read port, contents are never reset.
module apb3_mem_array #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  localparam int IdxW     = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [IdxW-1:0]      addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);
  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the output register is reset; it holds between read enables.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/apb3_mem_completer.sv
// APB3 completer backed by a word-addressed RAM. Zero-wait by default;
// define APB3_MEM_WAIT_STATE_EN to insert one wait state per transfer.
module apb3_mem_completer
  import apb3_mem_pkg::*;
#(
  parameter int AddressWidth = ADDR_W,
  parameter int DataWidth    = DATA_W,
  parameter int MemDepth     = MEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  apb3_mem_completer_if.slave  bus
);
  localparam int OffW = byte_off_w(DataWidth);
  localparam int IdxW = $clog2(MemDepth);

  typedef logic [IdxW-1:0]      idx_t;
  typedef logic [DataWidth-1:0] data_t;

  logic  setup_ph, access_ph, ready, ram_we, ram_re;
  idx_t  idx;
  data_t rdata;
  logic  unused_paddr;

  assign setup_ph  = bus.psel & ~bus.penable;
  assign access_ph = bus.psel &  bus.penable;

  // Byte-offset and upper bits are dropped, so addresses alias modulo MemDepth.
  assign idx          = bus.paddr[OffW +: IdxW];
  assign unused_paddr = ^bus.paddr;

`ifdef APB3_MEM_WAIT_STATE_EN
  wait_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup_ph) state_d = WAIT;
      WAIT:    state_d = bus.psel ? READY : IDLE;
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == READY) & access_ph & ~rst;
  end
`else
  assign ready = access_ph & ~rst;
`endif

  // Setup and access phases are exclusive, so the single port never sees both.
  assign ram_we = ready & bus.pwrite;
  assign ram_re = setup_ph & ~bus.pwrite & ~rst;

  apb3_mem_array #(
    .DataWidth (DataWidth),
    .Depth     (MemDepth)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx),
    .wdata (bus.pwdata),
    .rdata (rdata)
  );

  assign bus.pready = ready;
  assign bus.prdata = rdata;
endmodule

// File: tb/tb_apb3_mem_completer.sv
// Directed bench for apb3_mem_completer; adapts expected wait count to APB3_MEM_WAIT_STATE_EN.
module tb_apb3_mem_completer;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
`ifdef APB3_MEM_WAIT_STATE_EN
  localparam int EXP_WAIT = 1;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  apb3_mem_completer_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  apb3_mem_completer #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .MemDepth     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic setup(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.paddr = a; bus.pwrite = w; bus.pwdata = d;
    @(negedge clk);
    check("setup_pready", 64'(bus.pready), 64'd0);
    @(posedge clk); #1;
    bus.penable = 1'b1;
  endtask

  // Waits (bounded) for pready in the access phase; returns prdata sampled there.
  task automatic access(input string tag, output logic [DW-1:0] rd);
    int waits = 0;
    forever begin
      @(negedge clk);
      if (bus.pready) break;
      waits++;
      if (waits > 4) break;
      @(posedge clk); #1;
    end
    check({tag, "_waits"}, 64'(waits), 64'(EXP_WAIT));
    rd = bus.prdata;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] dummy;
    setup(a, 1'b1, d);
    access("wr", dummy);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] got;
    setup(a, 1'b0, '0);
    access(tag, got);
    check(tag, 64'(got), 64'(exp));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_prdata", 64'(bus.prdata), 64'd0);
    check("rst_pready", 64'(bus.pready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_pready", 64'(bus.pready), 64'd0);

    // Isolated writes then reads.
    for (int i = 0; i < 8; i++) begin
      wr(AW'(i * 4), 32'h1000_0000 + 32'(i));
      idle(1);
    end
    for (int i = 0; i < 8; i++) begin
      rd("single_rd", AW'(i * 4), 32'h1000_0000 + 32'(i));
      idle(1);
    end
    @(negedge clk);
    check("prdata_hold_idle", 64'(bus.prdata), 64'h1000_0007);

    // Back-to-back writes and reads.
    for (int i = 0; i < 8; i++) wr(AW'(32'h100 + 32'(i * 4)), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 8; i++) rd("b2b_rd", AW'(32'h100 + 32'(i * 4)), 32'hA5A5_0000 + 32'(i));
    idle(1);

    // Write immediately followed by read of the same word.
    wr(20'h40, 32'hDEAD_BEEF);
    rd("wr_then_rd", 20'h40, 32'hDEAD_BEEF);
    wr(20'h44, 32'h0BAD_F00D);
    @(negedge clk);
    check("prdata_hold_wr", 64'(bus.prdata), 64'hDEAD_BEEF);
    idle(1);

    // Aliasing and ignored byte offset.
    wr(20'h0, 32'h1234_5678);
    rd("alias_rd", 20'h1000, 32'h1234_5678);
    rd("offset_rd", 20'h2, 32'h1234_5678);
    idle(1);

    // Write/read at 0x8, then reset during the access phase of an overwrite.
    wr(20'h8, 32'hCAFE_F00D);
    rd("cafe_rd", 20'h8, 32'hCAFE_F00D);
    setup(20'h8, 1'b1, 32'h1111_1111);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_pready", 64'(bus.pready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    check("rst_abort_prdata", 64'(bus.prdata), 64'd0);
    rd("rst_abort_kept", 20'h8, 32'hCAFE_F00D);
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/apb3_mem_completer.md
Name: apb3_mem_completer

Overview:
- APB3 completer (slave) backed by a single-port word-addressed RAM.
- Accepts single and back-to-back APB3 read/write transfers from an upstream requester on the shared APB3 bus interface.
- Provides zero-wait-state responses by default.
- PSLVERR is not generated by this block; the integrator ties it to 0.

Parameters:
- AddressWidth, 20, width of paddr in bits (byte address).
- DataWidth, 32, width of pwdata/prdata in bits; must be 8, 16, 32 or 64.
- MemDepth, 1024, number of DataWidth-bit words; power of two, at least 2.

Ports:
- clk  input  1  bus clock (pclk); all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- paddr  input  AddressWidth  byte address.
- pwrite  input  1  1 = write, 0 = read.
- psel  input  1  completer select.
- penable  input  1  access-phase indicator.
- pwdata  input  DataWidth  write data.
- prdata  output  DataWidth  read data; valid when pready=1 in a read access phase.
- pready  output  1  transfer completion.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Word index = paddr[log2(DataWidth/8) +: log2(MemDepth)].
  - Low byte-offset bits are ignored.
  - Upper address bits are ignored, so addresses alias modulo MemDepth words.
- Setup phase = psel & ~penable. Access phase = psel & penable.
- Zero-wait mode (default):
  - pready = psel & penable (combinational).
  - Every transfer completes in 2 cycles: setup + access.
- Write: RAM word is written on the clk edge ending the access phase with pready=1 and pwrite=1. Full word only; no strobes (APB3).
- Read:
  - prdata is registered, loaded from RAM on the clk edge ending the setup phase when pwrite=0.
  - Held until the next read setup.
- Back-to-back transfers:
  - A new setup phase may immediately follow an access phase.
  - A read that follows a write to the same word in the next transfer returns the newly written data. The write commits at the end of the access phase, before the next setup phase's read sample.
- Idle (psel=0): no RAM access; prdata holds; pready=0.
- penable without psel is ignored.
- Reset:
  - prdata=0, pready=0, wait-state FSM to IDLE.
  - RAM contents are not cleared; unwritten words are undefined (X in simulation).
  - Reset asserted mid-transfer aborts the transfer and the write is not committed; the requester restarts from setup.
- Signals changing during an access phase while pready=0 are ignored until pready=1.

Optional Feature:
- Macro: APB3_MEM_WAIT_STATE_EN.
- Defined: one wait state per transfer via a registered FSM IDLE -> WAIT -> READY -> IDLE.
  - pready=0 in the first access-phase cycle and 1 in the second.
  - Transfers take 3 cycles.
  - Read data is still loaded at setup and held.
  - Write commits only in the cycle with pready=1.
  - FSM returns to IDLE if psel drops.
- Undefined: zero-wait mode as above; no FSM is instantiated.

Decomposition:
- Package apb3_mem_pkg holds:
  - default parameter constants: ADDR_W=20, DATA_W=32, MEM_DEPTH=1024;
  - helper function for byte-offset width;
  - wait-state FSM enum (IDLE, WAIT, READY).
- Address/data typedefs are derived locally from parameters.
- One sub-module: apb3_mem_array, a synchronous single-port RAM (we, addr, wdata, rdata registered, no reset on contents).

Test Plan:
- Reset: hold rst=1 for 2 cycles -> prdata=0, pready=0. After release with psel=0 -> pready stays 0.
- Single writes/reads:
  - Write 0x1000_0000+i to addresses 0x00,0x04,...,0x1C (i=0..7) as isolated transfers with idle cycles between, then read them back.
  - Each read returns 0x1000_0000+i with pready=1 in the access cycle; each transfer spans exactly 2 cycles.
- Back-to-back:
  - 8 writes of 0xA5A5_0000+i with no idle gaps, then 8 back-to-back reads.
  - Every access phase has pready=1; data matches; no dropped or duplicated write.
- Write-then-read same word: write 0xDEAD_BEEF at 0x40 immediately followed by a read of 0x40 -> prdata=0xDEAD_BEEF.
- Aliasing/offset:
  - Write 0x1234_5678 at 0x0 -> read of 0x1000 (1024 words * 4 bytes) returns 0x1234_5678.
  - Read of 0x2 returns the same word.
- APB3_MEM_WAIT_STATE_EN defined:
  - Single write+read of 0xCAFE_F00D at 0x8 -> pready low for exactly 1 access cycle; data correct.
  - Reset asserted in WAIT -> no write is committed; prior content is retained.
